fifo_multi_clearable: RTL and testbench



---
 rtl/fifo_multi_clearable_pkg.sv | 10 +
 rtl/fifo_channel_clearable.sv | 102 ++++++++++
 rtl/fifo_multi_clearable.sv | 48 ++++
 tb/tb_fifo_multi_clearable.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_multi_clearable_pkg.sv
// Shared types for the multi-channel clearable FIFO bank.
// Only the per-channel clear state lives here; widths stay local to each module.
package fifo_multi_clearable_pkg;

  typedef enum logic {
    CLR_IDLE    = 1'b0,
    CLR_PENDING = 1'b1
  } clear_state_e;

endpackage

// File: rtl/fifo_channel_clearable.sv
// One FIFO channel: binary pointers with an extra wrap bit, unreset storage,
// and a clear FSM that holds the channel closed for CLEAR_CYCLES cycles.
module fifo_channel_clearable
  import fifo_multi_clearable_pkg::*;
#(
  parameter type T            = logic [31:0],
  parameter int  LOG_DEPTH    = 3,
  parameter int  CLEAR_CYCLES = 2,
  parameter int  ALMOST_FULL  = (2**LOG_DEPTH) - 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  output logic             clear_pending_o,
  input  T                 data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output T                 data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [LOG_DEPTH:0] usage_o,
  output logic             almost_full_o
);

  localparam int DEPTH = 2**LOG_DEPTH;
  localparam int PW    = LOG_DEPTH + 1;
  localparam int CW    = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0] AF_P     = PW'(ALMOST_FULL);
  localparam logic [CW-1:0] CNT_INIT = CW'(CLEAR_CYCLES - 1);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  clear_state_e  state_q, state_d;
  T              mem_q [DEPTH];

  logic [PW-1:0] usage;
  logic          full, empty, pending, push, pop;

  // Handshake and status; only ready_o looks at an input (clear_i).
  always_comb begin
    usage           = wptr_q - rptr_q;
    full            = (usage == DEPTH_P);
    empty           = (usage == '0);
    pending         = (state_q == CLR_PENDING);
    ready_o         = !full && !clear_i && !pending;
    valid_o         = !empty && !pending;
    push            = valid_i && ready_o;
    pop             = valid_o && ready_i && !clear_i;
    usage_o         = pending ? '0 : usage;
    almost_full_o   = !pending && (usage >= AF_P);
    clear_pending_o = pending;
    data_o          = valid_o ? mem_q[rptr_q[LOG_DEPTH-1:0]] : '0;
  end

  // A clear dominates any same-cycle push or pop and (re)starts the window.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      cnt_d   = CNT_INIT;
      state_d = CLR_PENDING;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      if (pending) begin
        if (cnt_q == '0) state_d = CLR_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      state_q <= CLR_IDLE;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[LOG_DEPTH-1:0]] <= data_i;
  end

  // Re-clearing an already pending channel is a protocol violation upstream.
  a_no_clear_while_pending: assert property (
    @(posedge clk_i) disable iff (rst_i) !(pending && clear_i)
  );

endmodule

// File: rtl/fifo_multi_clearable.sv
// Bank of NUM_CH independent clearable FIFOs sharing one clock and reset.
module fifo_multi_clearable
  import fifo_multi_clearable_pkg::*;
#(
  parameter int  NUM_CH       = 4,
  parameter int  WIDTH        = 32,
  parameter type T            = logic [WIDTH-1:0],
  parameter int  LOG_DEPTH    = 3,
  parameter int  CLEAR_CYCLES = 2,
  parameter int  ALMOST_FULL  = (2**LOG_DEPTH) - 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_CH-1:0]                 clear_i,
  output logic [NUM_CH-1:0]                 clear_pending_o,
  input  T     [NUM_CH-1:0]                 data_i,
  input  logic [NUM_CH-1:0]                 valid_i,
  output logic [NUM_CH-1:0]                 ready_o,
  output T     [NUM_CH-1:0]                 data_o,
  output logic [NUM_CH-1:0]                 valid_o,
  input  logic [NUM_CH-1:0]                 ready_i,
  output logic [NUM_CH-1:0][LOG_DEPTH:0]    usage_o,
  output logic [NUM_CH-1:0]                 almost_full_o
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fifo_channel_clearable #(
      .T            (T),
      .LOG_DEPTH    (LOG_DEPTH),
      .CLEAR_CYCLES (CLEAR_CYCLES),
      .ALMOST_FULL  (ALMOST_FULL)
    ) u_ch (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .clear_i         (clear_i[c]),
      .clear_pending_o (clear_pending_o[c]),
      .data_i          (data_i[c]),
      .valid_i         (valid_i[c]),
      .ready_o         (ready_o[c]),
      .data_o          (data_o[c]),
      .valid_o         (valid_o[c]),
      .ready_i         (ready_i[c]),
      .usage_o         (usage_o[c]),
      .almost_full_o   (almost_full_o[c])
    );
  end

endmodule

// File: tb/tb_fifo_multi_clearable.sv
// Directed and randomized bench for fifo_multi_clearable, checked every cycle
// against a queue-based model of each channel.
module tb_fifo_multi_clearable;

  localparam int NCH = 4;
  localparam int DEPTH = 8;
  localparam int CLRC = 2;
  localparam int AFULL = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NCH-1:0]       clear, valid_in, ready_in;
  logic [NCH-1:0][31:0] din, dout;
  logic [NCH-1:0]       cp, ready_out, valid_out, af;
  logic [NCH-1:0][3:0]  usage;

  logic [31:0] q [NCH][$];
  int          pend [NCH];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  fifo_multi_clearable dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .clear_i         (clear),
    .clear_pending_o (cp),
    .data_i          (din),
    .valid_i         (valid_in),
    .ready_o         (ready_out),
    .data_o          (dout),
    .valid_o         (valid_out),
    .ready_i         (ready_in),
    .usage_o         (usage),
    .almost_full_o   (af)
  );

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic idle();
    clear = '0; valid_in = '0; ready_in = '0;
  endtask

  // Compare all outputs on the falling edge, then advance the model on the rising edge.
  task automatic step(input bit do_chk);
    @(negedge clk);
    if (do_chk) begin
      for (int c = 0; c < NCH; c++) begin
        int sz;
        bit p;
        sz = q[c].size();
        p  = (pend[c] > 0);
        chk("ready",  c, 32'(ready_out[c]), 32'(sz < DEPTH && !clear[c] && !p));
        chk("valid",  c, 32'(valid_out[c]), 32'(sz > 0 && !p));
        chk("usage",  c, 32'(usage[c]),     32'(p ? 0 : sz));
        chk("afull",  c, 32'(af[c]),        32'(!p && sz >= AFULL));
        chk("cpend",  c, 32'(cp[c]),        32'(p));
        chk("data",   c, dout[c],           (sz > 0 && !p) ? q[c][0] : 32'h0);
      end
    end
    @(posedge clk);
    for (int c = 0; c < NCH; c++) begin
      bit acc_push, acc_pop;
      if (rst) begin
        q[c].delete();
        pend[c] = 0;
      end else if (clear[c]) begin
        q[c].delete();
        pend[c] = CLRC;
      end else begin
        acc_push = valid_in[c] && q[c].size() < DEPTH && pend[c] == 0;
        acc_pop  = ready_in[c] && q[c].size() > 0 && pend[c] == 0;
        if (pend[c] > 0) pend[c]--;
        if (acc_pop)  void'(q[c].pop_front());
        if (acc_push) q[c].push_back(din[c]);
      end
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushes, pops, cyc;
    for (int c = 0; c < NCH; c++) pend[c] = 0;
    din = '0;
    idle();

    // Reset
    rst = 1'b1;
    step(1'b0);
    step(1'b1);
    rst = 1'b0;
    chk("rst_ready", 0, 32'(ready_out), 32'hF);
    chk("rst_valid", 0, 32'(valid_out), 32'h0);
    chk("rst_usage", 0, 32'(usage),     32'h0);
    chk("rst_cpend", 0, 32'(cp),        32'h0);

    // Fill ch0 then drain it
    for (int i = 0; i < DEPTH; i++) begin
      valid_in[0] = 1'b1; din[0] = 32'h10 + 32'(i);
      step(1'b1);
    end
    idle();
    chk("fill_usage", 0, 32'(usage[0]),     32'd8);
    chk("fill_ready", 0, 32'(ready_out[0]), 32'd0);
    ready_in[0] = 1'b1;
    for (int i = 0; i < DEPTH; i++) step(1'b1);
    idle();
    chk("drain_valid", 0, 32'(valid_out[0]), 32'd0);

    // Latency and simultaneous push/pop on ch1
    valid_in[1] = 1'b1; din[1] = $urandom;
    step(1'b1);
    idle();
    chk("lat_valid", 1, 32'(valid_out[1]), 32'd1);
    for (int i = 0; i < 2; i++) begin
      valid_in[1] = 1'b1; din[1] = $urandom;
      step(1'b1);
    end
    valid_in[1] = 1'b1; ready_in[1] = 1'b1; din[1] = $urandom;
    step(1'b1);
    idle();
    chk("pp_usage", 1, 32'(usage[1]), 32'd3);

    // Clear ch2 while it holds five words and sees a push and a pop
    for (int i = 0; i < 5; i++) begin
      valid_in[2] = 1'b1; din[2] = $urandom;
      step(1'b1);
    end
    clear[2] = 1'b1; valid_in[2] = 1'b1; ready_in[2] = 1'b1; din[2] = 32'hDEAD_BEEF;
    step(1'b1);
    idle();
    chk("clr_cp1", 2, 32'(cp[2]), 32'd1);
    step(1'b1);
    chk("clr_cp2", 2, 32'(cp[2]), 32'd1);
    step(1'b1);
    chk("clr_done", 2, 32'(cp[2]), 32'd0);
    valid_in[2] = 1'b1; din[2] = 32'hC0DE_0002;
    step(1'b1);
    idle();
    chk("clr_only", 2, 32'(usage[2]), 32'd1);
    chk("clr_head", 2, dout[2],       32'hC0DE_0002);

    // Full ch3 sees push and pop together
    for (int i = 0; i < DEPTH; i++) begin
      valid_in[3] = 1'b1; din[3] = $urandom;
      step(1'b1);
    end
    valid_in[3] = 1'b1; ready_in[3] = 1'b1; din[3] = 32'hBAD0_0003;
    step(1'b1);
    idle();
    chk("full_usage", 3, 32'(usage[3]),     32'd7);
    chk("full_ready", 3, 32'(ready_out[3]), 32'd1);

    // Random traffic: 40 pushes and pops through ch0, random activity elsewhere
    pushes = 0; pops = 0; cyc = 0;
    while ((pushes < 40 || pops < 40) && cyc < 600) begin
      bit pu, po;
      pu = (pushes < 40) && ($urandom_range(0, 3) != 0);
      po = ($urandom_range(0, 2) != 0);
      valid_in[0] = pu;
      ready_in[0] = po;
      din[0] = $urandom;
      if (pu && q[0].size() < DEPTH) pushes++;
      if (po && q[0].size() > 0) pops++;
      for (int c = 1; c < NCH; c++) begin
        valid_in[c] = 1'($urandom_range(0, 1));
        ready_in[c] = 1'($urandom_range(0, 1));
        din[c]      = $urandom;
        clear[c]    = (pend[c] == 0) && ($urandom_range(0, 15) == 0);
      end
      step(1'b1);
      chk("wrap_bound", 0, 32'(usage[0] <= 4'd8), 32'd1);
      cyc++;
    end
    idle();
    chk("wrap_done", 0, 32'(pushes == 40 && pops == 40), 32'd1);
    for (int i = 0; i < CLRC; i++) step(1'b1);

    // Reset during a clear window
    clear[1] = 1'b1;
    step(1'b1);
    idle();
    chk("rstclr_cp", 1, 32'(cp[1]), 32'd1);
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    chk("rstclr_done", 1, 32'(cp[1]), 32'd0);
    step(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
